// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch stage
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [4:0]  OPC_HALT  = 5'b00000;
  localparam logic [4:0]  OPC_NOP   = 5'b00001;

  // opcode lives in the top five bits of an instruction word
  function automatic logic [4:0] opcode_of(input logic [15:0] instr);
    return instr[15:11];
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// rtl/fetch_hold_buf.sv - single-entry holding buffer for a fetched instruction
module fetch_hold_buf #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] data
);

  // load wins over clear; the two are never requested together by the fetch stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ifid_ctrl.sv
// rtl/fetch_ifid_ctrl.sv - fetch stage with PC, holding buffer and IF/ID latch; FETCH_PERF_CNT_EN adds miss/squash counters
module fetch_ifid_ctrl
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_rd,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_stall,
  input  logic            imem_done,
  input  logic [PC_W-1:0] imem_instr,
  input  logic            disablePCWrite,
  input  logic            disableIFIDWrite,
  input  logic            setFetchNOP,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [4:0]      opcode_f,
  output logic [PC_W-1:0] instr_d,
  output logic [PC_W-1:0] pc_plus2_d,
  output logic            valid_d
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]     imiss_cycles,
  output logic [15:0]     squash_cnt
`endif
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next2;
  logic [PC_W-1:0] buf_data;
  logic [PC_W-1:0] avail_instr;
  logic            buf_valid;
  logic            fetching;
  logic            accepted;
  logic            avail;
  logic            consume;
  logic            is_halt;
  logic            buf_load;
  logic            buf_clear;

  // memory data only counts while a request of ours is outstanding
  assign fetching    = (state == REQ) || (state == WAIT);
  assign imem_rd     = rst && (state == REQ) && !buf_valid;
  assign imem_addr   = pc;
  assign accepted    = imem_rd && !imem_stall;
  assign avail       = buf_valid || (imem_done && fetching);
  assign avail_instr = buf_valid ? buf_data : imem_instr;
  assign opcode_f    = avail ? avail_instr[PC_W-1 -: 5] : OPC_NOP;
  assign is_halt     = (avail_instr[PC_W-1 -: 5] == OPC_HALT);
  assign consume     = avail && !disablePCWrite && !disableIFIDWrite &&
                       !setFetchNOP && !redirect_valid;
  assign pc_next2    = pc + PC_W'(2);
  assign buf_load    = avail && !consume && !redirect_valid;
  assign buf_clear   = consume || redirect_valid;

  fetch_hold_buf #(.W(PC_W)) u_hold_buf (
    .clk   (clk),
    .rst   (rst),
    .load  (buf_load),
    .clear (buf_clear),
    .din   (avail_instr),
    .valid (buf_valid),
    .data  (buf_data)
  );

  // PC and fetch FSM; a redirect always wins over sequential advance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= REQ;
      pc    <= RESET_PC;
    end else begin
      if (redirect_valid)
        pc <= redirect_pc;
      else if (consume)
        pc <= pc_next2;
      case (state)
        REQ: begin
          if (redirect_valid) begin
            if (accepted && !imem_done) state <= DRAIN;
          end else if (consume && is_halt) begin
            state <= HALT;
          end else if (accepted && !imem_done) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (imem_done)
            state <= (consume && is_halt) ? HALT : REQ;
          else if (redirect_valid)
            state <= DRAIN;
        end
        DRAIN: begin
          if (imem_done) state <= REQ;
        end
        HALT: begin
          if (redirect_valid) state <= REQ;
        end
        default: state <= REQ;
      endcase
    end
  end

  // IF/ID latch: load the instruction, insert a bubble, or hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_d    <= PC_W'(NOP_INSTR);
      pc_plus2_d <= '0;
      valid_d    <= 1'b0;
    end else if (!disableIFIDWrite) begin
      if (consume) begin
        instr_d    <= avail_instr;
        pc_plus2_d <= pc_next2;
        valid_d    <= 1'b1;
      end else begin
        instr_d    <= PC_W'(NOP_INSTR);
        pc_plus2_d <= '0;
        valid_d    <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic squash_evt;

  // a drained miss is counted when its data finally returns
  assign squash_evt = (redirect_valid && avail) || ((state == DRAIN) && imem_done);

  // saturating miss-cycle and squash counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imiss_cycles <= '0;
      squash_cnt   <= '0;
    end else begin
      if (((state == WAIT) || (state == DRAIN)) && (imiss_cycles != 16'hFFFF))
        imiss_cycles <= imiss_cycles + 16'd1;
      if (squash_evt && (squash_cnt != 16'hFFFF))
        squash_cnt <= squash_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ifid_ctrl.sv
// tb/tb_fetch_ifid_ctrl.sv - self-checking bench for fetch_ifid_ctrl
module tb_fetch_ifid_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic        imem_stall = 1'b0;
  logic        imem_done = 1'b0;
  logic [15:0] imem_instr = 16'h0;
  logic        disablePCWrite = 1'b0;
  logic        disableIFIDWrite = 1'b0;
  logic        setFetchNOP = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic [4:0]  opcode_f;
  logic [15:0] instr_d;
  logic [15:0] pc_plus2_d;
  logic        valid_d;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] imiss_cycles;
  logic [15:0] squash_cnt;
`endif

  fetch_ifid_ctrl #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_rd          (imem_rd),
    .imem_addr        (imem_addr),
    .imem_stall       (imem_stall),
    .imem_done        (imem_done),
    .imem_instr       (imem_instr),
    .disablePCWrite   (disablePCWrite),
    .disableIFIDWrite (disableIFIDWrite),
    .setFetchNOP      (setFetchNOP),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .opcode_f         (opcode_f),
    .instr_d          (instr_d),
    .pc_plus2_d       (pc_plus2_d),
    .valid_d          (valid_d)
`ifdef FETCH_PERF_CNT_EN
    ,
    .imiss_cycles     (imiss_cycles),
    .squash_cnt       (squash_cnt)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [15:0] NOP = 16'h0800;

  // memory image and per-word latency (0 = hit, N = done N cycles after request)
  logic [15:0] mem [256];
  int          lat [256];
  int          pend = 0;
  logic [15:0] pend_data = 16'h0;

  int checks = 0;
  int errors = 0;

  function automatic int idx(input logic [15:0] a);
    return int'(a[8:1]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // apply this cycle's controls and the memory's response to the current request
  task automatic drive(input logic dpc, input logic difid, input logic nop,
                       input logic rv, input logic [15:0] rpc, input logic st);
    disablePCWrite   = dpc;
    disableIFIDWrite = difid;
    setFetchNOP      = nop;
    redirect_valid   = rv;
    redirect_pc      = rpc;
    imem_stall       = st;
    if (pend > 0) begin
      imem_done  = (pend == 1);
      imem_instr = (pend == 1) ? pend_data : 16'hDEAD;
    end else if (imem_rd && !st && lat[idx(imem_addr)] == 0) begin
      imem_done  = 1'b1;
      imem_instr = mem[idx(imem_addr)];
    end else begin
      imem_done  = 1'b0;
      imem_instr = 16'hDEAD;
    end
    #1;
  endtask

  task automatic step_clk();
    logic        rd_s;
    logic        st_s;
    logic [15:0] a_s;
    rd_s = imem_rd;
    st_s = imem_stall;
    a_s  = imem_addr;
    @(posedge clk);
    if (!rst) pend = 0;
    else if (pend > 0) pend--;
    else if (rd_s && !st_s && lat[idx(a_s)] != 0) begin
      pend      = lat[idx(a_s)];
      pend_data = mem[idx(a_s)];
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(0, 0, 0, 0, 16'h0, 0);
    step_clk();
    rst = 1'b1;
    #1;
  endtask

  logic [15:0] w;
  logic [15:0] saved;
  logic [15:0] exp_addr;
  logic [15:0] m_instr, m_pc2;
  logic        m_valid, m_held, av, cons;
  logic        r_dpc, r_difid, r_nop, r_st;
  int          delivered;

  // directed scenarios followed by a randomized run against a stream-level model
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = {5'((i % 30) + 2), 11'(i * 7 + 3)};
      lat[i] = 0;
    end

    // reset values
    rst = 1'b0;
    drive(0, 0, 0, 0, 16'h0, 0);
    chk("rst_rd", imem_rd, 1'b0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_opc", opcode_f, 5'b00001);
    step_clk();
    chk("rst_instr", instr_d, NOP);
    chk("rst_pc2", pc_plus2_d, 16'h0);
    chk("rst_valid", valid_d, 1'b0);
    rst = 1'b1;
    #1;

    // 1: hit every cycle
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 16'h0, 0);
      chk("t1_rd", imem_rd, 1'b1);
      chk("t1_addr", imem_addr, 32'(2 * i));
      chk("t1_opc", opcode_f, mem[i][15:11]);
      step_clk();
      chk("t1_instr", instr_d, mem[i]);
      chk("t1_pc2", pc_plus2_d, 32'(2 * i + 2));
      chk("t1_valid", valid_d, 1'b1);
    end

    // 2: four-cycle miss at 0x0002
    do_reset();
    lat[1] = 4;
    drive(0, 0, 0, 0, 16'h0, 0);
    step_clk();
    drive(0, 0, 0, 0, 16'h0, 0);
    chk("t2_req_addr", imem_addr, 16'h0002);
    step_clk();
    chk("t2_bubble", instr_d, NOP);
    chk("t2_bubble_v", valid_d, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 16'h0, 0);
      chk("t2_rd", imem_rd, 1'b0);
      chk("t2_addr", imem_addr, 16'h0002);
      step_clk();
      if (k < 3) begin
        chk("t2_wait_instr", instr_d, NOP);
        chk("t2_wait_valid", valid_d, 1'b0);
      end else begin
        chk("t2_done_instr", instr_d, mem[1]);
        chk("t2_done_pc2", pc_plus2_d, 16'h0004);
        chk("t2_done_valid", valid_d, 1'b1);
      end
    end
    drive(0, 0, 0, 0, 16'h0, 0);
    chk("t2_next_rd", imem_rd, 1'b1);
    chk("t2_next_addr", imem_addr, 16'h0004);
    step_clk();
    lat[1] = 0;

    // 3: IF/ID held for two cycles while a hit returns
    do_reset();
    drive(0, 0, 0, 0, 16'h0, 0);
    step_clk();
    drive(0, 1, 0, 0, 16'h0, 0);
    chk("t3_rd0", imem_rd, 1'b1);
    step_clk();
    chk("t3_hold_instr", instr_d, mem[0]);
    chk("t3_hold_pc2", pc_plus2_d, 16'h0002);
    drive(0, 1, 0, 0, 16'h0, 0);
    chk("t3_rd1", imem_rd, 1'b0);
    chk("t3_opc", opcode_f, mem[1][15:11]);
    step_clk();
    chk("t3_hold2_instr", instr_d, mem[0]);
    chk("t3_hold2_valid", valid_d, 1'b1);
    drive(0, 0, 0, 0, 16'h0, 0);
    chk("t3_rd2", imem_rd, 1'b0);
    chk("t3_addr2", imem_addr, 16'h0002);
    step_clk();
    chk("t3_rel_instr", instr_d, mem[1]);
    chk("t3_rel_pc2", pc_plus2_d, 16'h0004);
    drive(0, 0, 0, 0, 16'h0, 0);
    chk("t3_next_addr", imem_addr, 16'h0004);
    chk("t3_next_rd", imem_rd, 1'b1);
    step_clk();

    // 4: redirect during a miss
    do_reset();
    lat[1] = 3;
    drive(0, 0, 0, 0, 16'h0, 0);
    step_clk();
    drive(0, 0, 0, 0, 16'h0, 0);
    step_clk();
    drive(0, 0, 0, 1, 16'h0040, 0);
    chk("t4_rd_wait", imem_rd, 1'b0);
    step_clk();
    chk("t4_redir_instr", instr_d, NOP);
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 0, 16'h0, 0);
      chk("t4_drain_rd", imem_rd, 1'b0);
      chk("t4_drain_addr", imem_addr, 16'h0040);
      step_clk();
      chk("t4_drain_instr", instr_d, NOP);
      chk("t4_drain_valid", valid_d, 1'b0);
    end
    drive(0, 0, 0, 0, 16'h0, 0);
    chk("t4_new_rd", imem_rd, 1'b1);
    chk("t4_new_addr", imem_addr, 16'h0040);
    step_clk();
    chk("t4_new_instr", instr_d, mem[32]);
    chk("t4_new_pc2", pc_plus2_d, 16'h0042);
`ifdef FETCH_PERF_CNT_EN
    chk("t4_squash", squash_cnt, 16'd1);
    chk("t4_imiss", imiss_cycles, 16'd3);
`endif
    lat[1] = 0;

    // 5: halt at 0x0006, restart by redirect
    do_reset();
    saved  = mem[3];
    mem[3] = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 16'h0, 0);
      step_clk();
    end
    drive(0, 0, 0, 0, 16'h0, 0);
    chk("t5_addr", imem_addr, 16'h0006);
    chk("t5_opc", opcode_f, 5'b00000);
    step_clk();
    chk("t5_halt_instr", instr_d, 16'h0000);
    chk("t5_halt_valid", valid_d, 1'b1);
    chk("t5_halt_pc2", pc_plus2_d, 16'h0008);
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 0, 16'h0, 0);
      chk("t5_halt_rd", imem_rd, 1'b0);
      chk("t5_halt_addr", imem_addr, 16'h0008);
      step_clk();
      chk("t5_halt_bubble", instr_d, NOP);
    end
    drive(0, 0, 0, 1, 16'h0010, 0);
    step_clk();
    drive(0, 0, 0, 0, 16'h0, 0);
    chk("t5_restart_rd", imem_rd, 1'b1);
    chk("t5_restart_addr", imem_addr, 16'h0010);
    step_clk();
    chk("t5_restart_instr", instr_d, mem[8]);
    chk("t5_restart_pc2", pc_plus2_d, 16'h0012);
    mem[3] = saved;

    // 6: setFetchNOP + disablePCWrite with a valid hit
    do_reset();
    drive(0, 0, 0, 0, 16'h0, 0);
    step_clk();
    drive(1, 0, 1, 0, 16'h0, 0);
    chk("t6_rd", imem_rd, 1'b1);
    step_clk();
    chk("t6_nop_instr", instr_d, NOP);
    chk("t6_nop_valid", valid_d, 1'b0);
    chk("t6_nop_pc2", pc_plus2_d, 16'h0);
    drive(1, 0, 1, 0, 16'h0, 0);
    chk("t6_hold_rd", imem_rd, 1'b0);
    chk("t6_hold_addr", imem_addr, 16'h0002);
    step_clk();
    chk("t6_nop2_instr", instr_d, NOP);
    drive(0, 0, 0, 0, 16'h0, 0);
    chk("t6_buf_opc", opcode_f, mem[1][15:11]);
    step_clk();
    chk("t6_rel_instr", instr_d, mem[1]);
    chk("t6_rel_pc2", pc_plus2_d, 16'h0004);
    chk("t6_rel_valid", valid_d, 1'b1);
    drive(0, 0, 0, 0, 16'h0, 0);
    chk("t6_next_addr", imem_addr, 16'h0004);
    step_clk();

    // randomized run: sequential program, random latency, stalls and hazards
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      if (w[15:11] == 5'b00000) w[15:11] = 5'b00011;
      mem[i] = w;
      lat[i] = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 4));
    end
    do_reset();
    exp_addr  = 16'h0;
    m_instr   = NOP;
    m_pc2     = 16'h0;
    m_valid   = 1'b0;
    m_held    = 1'b0;
    delivered = 0;
    for (int c = 0; c < 600; c++) begin
      r_dpc   = ($urandom_range(0, 5) == 0);
      r_difid = ($urandom_range(0, 5) == 0);
      r_nop   = ($urandom_range(0, 6) == 0);
      r_st    = ($urandom_range(0, 4) == 0);
      drive(r_dpc, r_difid, r_nop, 0, 16'h0, r_st);
      av   = m_held || imem_done;
      cons = av && !r_dpc && !r_difid && !r_nop;
      chk("rnd_rd", imem_rd, (pend == 0) && !m_held);
      if (imem_rd) chk("rnd_addr", imem_addr, exp_addr);
      chk("rnd_opc", opcode_f, av ? mem[idx(exp_addr)][15:11] : 5'b00001);
      step_clk();
      if (!r_difid) begin
        if (cons) begin
          m_instr = mem[idx(exp_addr)];
          m_pc2   = exp_addr + 16'd2;
          m_valid = 1'b1;
          exp_addr = exp_addr + 16'd2;
          delivered++;
        end else begin
          m_instr = NOP;
          m_pc2   = 16'h0;
          m_valid = 1'b0;
        end
      end
      m_held = av && !cons;
      chk("rnd_instr", instr_d, m_instr);
      chk("rnd_pc2", pc_plus2_d, m_pc2);
      chk("rnd_valid", valid_d, m_valid);
    end
    chk("rnd_progress", delivered >= 60, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
